shift_queue: RTL and testbench
==============================

Name: shift_queue

Overview:
- Collapsing (shifting) queue used as the integer issue queue (IIQ) storage.
- Entries are kept in age order: index 0 is the oldest.
- New entries are enqueued at the tail.
- Any single entry can be dequeued by one-hot select; younger entries shift down one slot to close the gap.
- Per-entry in-place write ports let the issue logic update stored entries, e.g. wakeup fields.

Parameters:
- N_ENTRIES, default 8: number of queue slots (≥2).
- ENTRY_WIDTH, default 32: bits per entry.
- PTR_WIDTH (localparam) = $clog2(N_ENTRIES): slot index width.
- CTR_WIDTH (localparam) = PTR_WIDTH+1: occupancy counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_aL  in  1  synchronous reset, active-high (1 = reset) despite the suffix.
- enq_ready  out  1  queue can accept an entry.
- enq_valid  in  1  enqueue request.
- enq_data  in  ENTRY_WIDTH  entry to enqueue.
- deq_ready  in  1  consumer takes the selected entry this cycle.
- deq_sel_onehot  in  N_ENTRIES  one-hot slot select, or all zeros meaning the head.
- deq_valid  out  1  the selected slot holds a valid entry.
- deq_data  out  ENTRY_WIDTH  data of the selected slot.
- wr_en  in  N_ENTRIES  per-slot overwrite enable.
- wr_data  in  N_ENTRIES x ENTRY_WIDTH  per-slot overwrite data (packed 2-D).
- entry_douts  out  N_ENTRIES x ENTRY_WIDTH  contents of every slot.

Behaviour:
- State:
  - valid[N_ENTRIES] and data[N_ENTRIES].
  - Valid slots are always contiguous from index 0.
  - count = number of valid slots.
- Reset (rst_aL=1 at a rising edge): all valid=0, all data=0, count=0. This also applies mid-operation; any enq/deq/write that cycle is discarded.
- Outputs after reset: enq_ready=1, deq_valid=0, deq_data=0, entry_douts all 0.
- enq_ready = (count < N_ENTRIES).
  - Combinational from state only; it does not depend on deq_ready.
  - A full queue refuses enqueue even when a dequeue occurs in the same cycle.
- Effective select:
  - sel = deq_sel_onehot when nonzero; otherwise one-hot of slot 0.
  - Multi-hot selects are illegal; the lowest set bit is used.
- Combinational dequeue outputs:
  - deq_data = data[sel].
  - deq_valid = valid[sel].
- Dequeue fires when deq_ready && deq_valid. On the next edge:
  - slots above the selected index k shift down (slot i ← slot i+1 for i ≥ k);
  - the top slot becomes invalid with data 0;
  - count decrements.
- Enqueue fires when enq_valid && enq_ready. The new entry is written to the first free slot after any shift:
  - index count, with no dequeue that cycle;
  - index count-1, when a dequeue fires the same cycle.
- Net count change on simultaneous enqueue and dequeue is 0.
- In-place writes:
  - wr_en[i] applies wr_data[i] to slot i only if valid[i]; writes to invalid slots are ignored.
  - Writes are applied before the shift, so the updated value moves with its entry.
  - A write to the slot being dequeued is discarded.
- entry_douts[i] = data[i]; invalid slots read 0.
- Read behaviour:
  - No bypass: data enqueued in a cycle becomes visible the following cycle.
  - An empty queue gives deq_valid=0 and deq_data=0.

Optional Feature:
- Macro: SHIFT_QUEUE_COUNT_OUT_EN.
- When defined, an extra output port count (CTR_WIDTH bits) presents the occupancy register.
  - Reset value 0.
  - Updated per the rules above.
- When undefined, the port is absent and the counter remains internal; queue behaviour is identical either way.

Test Plan:
- Reset, then hold deq_sel_onehot=0, deq_ready=0 -> enq_ready=1, deq_valid=0, deq_data=0, entry_douts=0 (count=0 when enabled).
- Enqueue 0x12345678 into empty queue -> next cycle: enq_ready=1, deq_valid=1, deq_data=0x12345678, count=1.
- Enqueue 0x87654321, then 0xABCDEF01 -> deq_data stays 0x12345678; count 2, then 3; entry_douts[2:0] = {ABCDEF01, 87654321, 12345678}.
- Dequeue the head (sel=0, deq_ready=1):
  - same cycle: deq_data=0x12345678;
  - next cycle: deq_data=0x87654321, count=2, entry_douts[1]=0xABCDEF01, entry_douts[2]=0.
- Middle dequeue with simultaneous enqueue:
  - setup: 3 entries A,B,C; sel=0b010, deq_ready=1, enq_valid=1 with D;
  - expected: slots become A,C,D, count=3.
- Stress cases:
  - Fill to N_ENTRIES -> enq_ready=0; enqueue attempts are ignored.
  - wr_en on slot 1 with 0x55AA55AA -> entry_douts[1] updated next cycle.
  - wr_en on an empty slot -> no change.
  - Reset asserted mid-fill -> all cleared.

Source files
------------

// File: rtl/shift_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_queue_if
// Description : Bundles the enqueue, dequeue and in-place write signals of the
//               collapsing issue-queue storage (shift_queue).
//   master modport (producer/consumer side):
//     drives  enq_valid, enq_data, deq_ready, deq_sel_onehot, wr_en, wr_data
//     samples enq_ready, deq_valid, deq_data, entry_douts
//   slave modport (shift_queue side): the mirror image of master.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_queue_if #(
  parameter int N_ENTRIES   = 8,
  parameter int ENTRY_WIDTH = 32
);
  logic                                    enq_ready;
  logic                                    enq_valid;
  logic [ENTRY_WIDTH-1:0]                  enq_data;
  logic                                    deq_ready;
  logic [N_ENTRIES-1:0]                    deq_sel_onehot;
  logic                                    deq_valid;
  logic [ENTRY_WIDTH-1:0]                  deq_data;
  logic [N_ENTRIES-1:0]                    wr_en;
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]   wr_data;
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]   entry_douts;

  modport master (
    input  enq_ready, deq_valid, deq_data, entry_douts,
    output enq_valid, enq_data, deq_ready, deq_sel_onehot, wr_en, wr_data
  );

  modport slave (
    output enq_ready, deq_valid, deq_data, entry_douts,
    input  enq_valid, enq_data, deq_ready, deq_sel_onehot, wr_en, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/shift_queue.sv
`default_nettype none
// ============================================================================
// Module      : shift_queue
// Description : Collapsing (shifting) queue used as integer issue queue
//               storage. Slot 0 is the oldest entry; valid slots are always
//               contiguous from slot 0. Any slot may be dequeued by one-hot
//               select and younger entries shift down to close the gap.
//               Per-slot write ports update stored entries in place.
// Ports       :
//   clk    - clock, all state changes on the rising edge
//   rst_aL - synchronous reset, active HIGH despite the suffix
//   bus    - shift_queue_if.slave (enqueue, dequeue, in-place write, douts)
//   count  - occupancy, present only when SHIFT_QUEUE_COUNT_OUT_EN is defined
// Options     : `define SHIFT_QUEUE_COUNT_OUT_EN exposes the occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_queue #(
  parameter int N_ENTRIES   = 8,
  parameter int ENTRY_WIDTH = 32
) (
  input  wire logic                       clk,
  input  wire logic                       rst_aL,
`ifdef SHIFT_QUEUE_COUNT_OUT_EN
  output logic [$clog2(N_ENTRIES):0]      count,
`endif
  shift_queue_if.slave                    bus
);

  localparam int PTR_WIDTH = $clog2(N_ENTRIES);
  localparam int CTR_WIDTH = PTR_WIDTH + 1;

  logic [N_ENTRIES-1:0]                  valid_q, valid_d;
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] data_q, data_d;
  logic [CTR_WIDTH-1:0]                  count_q, count_d;

  logic [N_ENTRIES-1:0]                  w_sel;       // effective one-hot select
  logic [N_ENTRIES-1:0]                  w_shift;     // slots that take slot i+1
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] w_wr;        // data after in-place writes
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] w_up_data;   // slot i+1 contents (post-write)
  logic [N_ENTRIES-1:0]                  w_up_valid;
  logic                                  w_enq_ready;
  logic                                  w_deq_valid;
  logic [ENTRY_WIDTH-1:0]                w_deq_data;
  logic                                  w_deq_fire;
  logic                                  w_enq_fire;
  logic [CTR_WIDTH-1:0]                  w_tail;

  // Zero select means head; a multi-hot select is reduced to its lowest bit.
  always_comb begin
    w_sel = bus.deq_sel_onehot & (~bus.deq_sel_onehot + N_ENTRIES'(1));
    if (bus.deq_sel_onehot == '0) begin
      w_sel = N_ENTRIES'(1);
    end
  end

  // Dequeue read mux; invalid slots hold zero so an empty pick reads zero.
  always_comb begin
    w_deq_data  = '0;
    w_deq_valid = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (w_sel[i]) begin
        w_deq_data  = w_deq_data | data_q[i];
        w_deq_valid = w_deq_valid | valid_q[i];
      end
    end
  end

  assign w_enq_ready = (count_q < CTR_WIDTH'(N_ENTRIES));
  assign w_deq_fire  = bus.deq_ready & w_deq_valid;
  assign w_enq_fire  = bus.enq_valid & w_enq_ready;
  assign w_tail      = w_deq_fire ? (count_q - CTR_WIDTH'(1)) : count_q;

  // In-place writes only touch valid slots. They are folded in before the
  // shift so an updated entry carries its new value down with it; a write to
  // the dequeued slot simply leaves with that slot.
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      w_wr[i] = (bus.wr_en[i] && valid_q[i]) ? bus.wr_data[i] : data_q[i];
    end
  end

  // Every slot at or above the dequeued index takes its upper neighbour.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    w_shift = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      acc        = acc | w_sel[i];
      w_shift[i] = acc & w_deq_fire;
    end
  end

  generate
    for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_up
      if (gi == N_ENTRIES - 1) begin : g_top
        assign w_up_data[gi]  = '0;
        assign w_up_valid[gi] = 1'b0;
      end else begin : g_mid
        assign w_up_data[gi]  = w_wr[gi+1];
        assign w_up_valid[gi] = valid_q[gi+1];
      end
    end
  endgenerate

  // Next state: shift first, then drop the new entry into the first free slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < N_ENTRIES; i++) begin
      valid_d[i] = w_shift[i] ? w_up_valid[i] : valid_q[i];
      data_d[i]  = w_shift[i] ? w_up_data[i]  : w_wr[i];
      if (w_enq_fire && (w_tail == CTR_WIDTH'(i))) begin
        valid_d[i] = 1'b1;
        data_d[i]  = bus.enq_data;
      end
    end
    count_d = count_q + CTR_WIDTH'(w_enq_fire) - CTR_WIDTH'(w_deq_fire);
  end

  always_ff @(posedge clk) begin
    if (rst_aL) begin
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign bus.enq_ready   = w_enq_ready;
  assign bus.deq_valid   = w_deq_valid;
  assign bus.deq_data    = w_deq_data;
  assign bus.entry_douts = data_q;

`ifdef SHIFT_QUEUE_COUNT_OUT_EN
  assign count = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_queue
// Description : Self-checking bench for shift_queue (N_ENTRIES=8, 32-bit).
//               The driver applies directed vectors and queues the expected
//               outputs for that cycle; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_queue;

  localparam int N = 8;
  localparam int W = 32;

  typedef struct packed {
    logic           er;
    logic           dv;
    logic [W-1:0]   dd;
    logic [255:0]   douts;
    logic [3:0]     cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;

  shift_queue_if #(.N_ENTRIES(N), .ENTRY_WIDTH(W)) bus ();

`ifdef SHIFT_QUEUE_COUNT_OUT_EN
  logic [3:0] count_o;
`endif

  shift_queue #(.N_ENTRIES(N), .ENTRY_WIDTH(W)) dut (
    .clk    (clk),
    .rst_aL (rst),
`ifdef SHIFT_QUEUE_COUNT_OUT_EN
    .count  (count_o),
`endif
    .bus    (bus)
  );

  function automatic logic [255:0] dts(
    input logic [31:0] s0 = 32'h0, input logic [31:0] s1 = 32'h0,
    input logic [31:0] s2 = 32'h0, input logic [31:0] s3 = 32'h0,
    input logic [31:0] s4 = 32'h0, input logic [31:0] s5 = 32'h0,
    input logic [31:0] s6 = 32'h0, input logic [31:0] s7 = 32'h0);
    return {s7, s6, s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic chk(input string nm, input string fld,
                     input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic er, input logic dv,
                            input logic [31:0] dd, input logic [255:0] douts,
                            input logic [3:0] cnt);
    exp_t e;
    e.er = er; e.dv = dv; e.dd = dd; e.douts = douts; e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One cycle: wait past the edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.enq_valid      = 1'b0;
    bus.enq_data       = '0;
    bus.deq_ready      = 1'b0;
    bus.deq_sel_onehot = '0;
    bus.wr_en          = '0;
    bus.wr_data        = '0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      chk(mon_nm, "enq_ready",   256'(bus.enq_ready),   256'(mon_e.er));
      chk(mon_nm, "deq_valid",   256'(bus.deq_valid),   256'(mon_e.dv));
      chk(mon_nm, "deq_data",    256'(bus.deq_data),    256'(mon_e.dd));
      chk(mon_nm, "entry_douts", 256'(bus.entry_douts), mon_e.douts);
`ifdef SHIFT_QUEUE_COUNT_OUT_EN
      chk(mon_nm, "count",       256'(count_o),         256'(mon_e.cnt));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [N-1:0][W-1:0] fill;

  initial begin
    bus.enq_valid      = 1'b0;
    bus.enq_data       = '0;
    bus.deq_ready      = 1'b0;
    bus.deq_sel_onehot = '0;
    bus.wr_en          = '0;
    bus.wr_data        = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);

    tick(); rst = 1'b0;
    expect_out("reset", 1, 0, 32'h0, 256'h0, 4'd0);

    tick(); bus.enq_valid = 1; bus.enq_data = 32'h12345678;
    expect_out("enq_a_no_bypass", 1, 0, 32'h0, 256'h0, 4'd0);

    tick(); bus.enq_valid = 1; bus.enq_data = 32'h87654321;
    expect_out("enq_b", 1, 1, 32'h12345678, dts(32'h12345678), 4'd1);

    tick(); bus.enq_valid = 1; bus.enq_data = 32'hABCDEF01;
    expect_out("enq_c", 1, 1, 32'h12345678, dts(32'h12345678, 32'h87654321), 4'd2);

    tick(); bus.deq_ready = 1;
    expect_out("deq_head_same", 1, 1, 32'h12345678,
               dts(32'h12345678, 32'h87654321, 32'hABCDEF01), 4'd3);

    tick();
    expect_out("deq_head_after", 1, 1, 32'h87654321,
               dts(32'h87654321, 32'hABCDEF01), 4'd2);

    tick(); bus.enq_valid = 1; bus.enq_data = 32'hC0000003;
    expect_out("enq_third", 1, 1, 32'h87654321,
               dts(32'h87654321, 32'hABCDEF01), 4'd2);

    // Middle dequeue of slot 1 together with an enqueue.
    tick(); bus.deq_ready = 1; bus.deq_sel_onehot = 8'b0000_0010;
    bus.enq_valid = 1; bus.enq_data = 32'hD0000004;
    expect_out("mid_deq_same", 1, 1, 32'hABCDEF01,
               dts(32'h87654321, 32'hABCDEF01, 32'hC0000003), 4'd3);

    // Writes under a head dequeue: slot 0 write is lost, others move down.
    tick(); bus.deq_ready = 1; bus.wr_en = 8'b0000_0111;
    bus.wr_data[0] = 32'hBAD00000; bus.wr_data[1] = 32'h11111111;
    bus.wr_data[2] = 32'hEEEE0002;
    expect_out("mid_deq_after", 1, 1, 32'h87654321,
               dts(32'h87654321, 32'hC0000003, 32'hD0000004), 4'd3);

    tick(); bus.wr_en = 8'b0010_0010;
    bus.wr_data[1] = 32'h55AA55AA; bus.wr_data[5] = 32'hFFFFFFFF;
    expect_out("write_shift", 1, 1, 32'h11111111,
               dts(32'h11111111, 32'hEEEE0002), 4'd2);

    tick();
    expect_out("write_slot1", 1, 1, 32'h11111111,
               dts(32'h11111111, 32'h55AA55AA), 4'd2);

    fill = '0;
    fill[0] = 32'h11111111;
    fill[1] = 32'h55AA55AA;
    for (int i = 0; i < 6; i++) begin
      tick(); bus.enq_valid = 1; bus.enq_data = 32'h100 + 32'(i);
      expect_out($sformatf("fill_%0d", i), 1, 1, 32'h11111111, fill, 4'(2 + i));
      fill[2+i] = 32'h100 + 32'(i);
    end

    tick(); bus.enq_valid = 1; bus.enq_data = 32'hDEADBEEF;
    expect_out("full_refuse", 0, 1, 32'h11111111, fill, 4'd8);

    tick(); bus.enq_valid = 1; bus.enq_data = 32'hDEADBEEF; bus.deq_ready = 1;
    expect_out("full_deq_no_enq", 0, 1, 32'h11111111, fill, 4'd8);

    tick(); bus.deq_ready = 1; bus.deq_sel_onehot = 8'h40;
    expect_out("deq_top_same", 1, 1, 32'h105,
               dts(32'h55AA55AA, 32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105), 4'd7);

    tick(); bus.deq_ready = 1; bus.deq_sel_onehot = 8'h80;
    expect_out("deq_invalid", 1, 0, 32'h0,
               dts(32'h55AA55AA, 32'h100, 32'h101, 32'h102, 32'h103, 32'h104), 4'd6);

    tick(); bus.deq_sel_onehot = 8'h0C;
    expect_out("multi_hot", 1, 1, 32'h101,
               dts(32'h55AA55AA, 32'h100, 32'h101, 32'h102, 32'h103, 32'h104), 4'd6);

    tick(); rst = 1'b1; bus.enq_valid = 1; bus.enq_data = 32'h99;
    bus.deq_ready = 1; bus.wr_en = 8'h01; bus.wr_data[0] = 32'h12;
    expect_out("rst_cycle", 1, 1, 32'h55AA55AA,
               dts(32'h55AA55AA, 32'h100, 32'h101, 32'h102, 32'h103, 32'h104), 4'd6);

    tick(); rst = 1'b0;
    expect_out("after_rst", 1, 0, 32'h0, 256'h0, 4'd0);

    tick(); bus.enq_valid = 1; bus.enq_data = 32'h77;
    expect_out("enq_post_rst", 1, 0, 32'h0, 256'h0, 4'd0);

    tick();
    expect_out("post_rst_data", 1, 1, 32'h77, dts(32'h77), 4'd1);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected records left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
